large_adder_arbiter: RTL and testbench
======================================

# large_adder_arbiter

Round-robin arbiter and sequencer that shares one `large_adder` datapath instance between `N_REQ` independent requesters. It accepts at most one operand word per cycle through valid/ready handshakes and drives it into the adder. It tracks each operation's requester ID through the adder's fixed latency and returns tagged results through a credit-protected response FIFO. It sits between the requester fabric and the adder, and is the only block that drives the adder's `data_in`.

## Interface
- `WIDTH`, 32: operand/result width; must match the adder instance.
- `N_REQ`, 4: number of requesters, 2..16.
- `ADD_LAT`, 1: cycles from `add_data_in` sampled to `add_data_out` valid.
- `RSP_DEPTH`, 4: response FIFO depth, power of two, at least `ADD_LAT`+1.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `N_REQ`: per-requester operand valid.
- `req_data` in `N_REQ`*`WIDTH`: operands; requester i occupies slice [i*WIDTH +: WIDTH].
- `req_ready` out `N_REQ`: one-hot grant; a transfer happens when `req_valid[i]` and `req_ready[i]` are both high.
- `add_data_in` out `WIDTH`: operand to the adder.
- `add_data_out` in `WIDTH`: result from the adder.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out `ID_W`: requester index of the response; `ID_W` = max(1, clog2(`N_REQ`)).
- `rsp_data` out `WIDTH`: adder result.
- `grant_cnt` out `N_REQ`*16: present only with `LARGE_ADDER_ARB_GRANT_CNT_EN`.

## Operation
- **Issue condition:** `fifo_count` + `inflight` < `RSP_DEPTH`, and `rst` is low. `fifo_count` and `inflight` are registered values; a pop in the same cycle is not credited.
- **Arbitration:**
  - When the issue condition holds, grant the lowest index i ≥ `rr_ptr` with `req_valid[i]`, wrapping to 0.
  - After a grant, `rr_ptr` becomes (i+1) mod `N_REQ`. With no grant, `rr_ptr` holds.
- **Ready generation:** `req_ready` is combinational from `req_valid` and state. Requesters must not make `req_valid` depend on `req_ready`.
- **Adder drive:** `add_data_in` carries the granted slice. It is 0 when there is no grant.
- **Tag pipeline:**
  - An `ADD_LAT`-deep shift register carries {valid, id} per cycle.
  - `inflight` is the number of valid stages.
  - When the last stage is valid, `add_data_out` and its id are pushed into the FIFO.
- **Response FIFO:**
  - `rsp_valid` = FIFO not empty; head is shown on `rsp_id`/`rsp_data`.
  - Pop on `rsp_valid` && `rsp_ready`.
  - Push and pop may occur in the same cycle.
  - The credit rule guarantees no overflow; overflow is a design error, assertion-checked.
- **Ordering:** responses leave in issue order.
- **Arithmetic:** the block never modifies data. `rsp_data` equals `add_data_out` bit-for-bit.
- **Reset (synchronous, applied in any state):**
  - Cleared: `rr_ptr`=0, tag pipeline, FIFO pointers, `grant_cnt`.
  - Outputs: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `add_data_in`=0.
  - Results in flight at reset are discarded. The adder shares `rst`.

## Timing
- Grant in cycle t: operand sampled by the adder at the end of t.
- Result pushed at the end of t+`ADD_LAT`.
- `rsp_valid` high in t+`ADD_LAT`+1. Accept-to-response latency is `ADD_LAT`+1 (2 by default).
- Throughput is one operation per cycle when `rsp_ready` stays high.
- With `rsp_ready` low, at most `RSP_DEPTH` operations are accepted. The first grant resumes one cycle after the first pop.

## Configuration
- **`LARGE_ADDER_ARB_GRANT_CNT_EN` defined:**
  - Adds a 16-bit counter per requester, incremented on each grant to it and saturating at 0xFFFF.
  - Cleared by `rst`, exported on `grant_cnt`.
- **Not defined:** no counters and no `grant_cnt` port. All other behaviour is identical.

## Structure
- Package `large_adder_arb_pkg` holds:
  - the `ID_W` computation function;
  - `GRANT_CNT_W` = 16;
  - the typedef of the tag-pipeline entry {valid, id}.
- Sub-module `large_adder_arb_rsp_fifo`: synchronous FIFO of {id, data}, parameterised depth, exposing count.
- Arbiter, credit logic and tag pipeline live in the top module.

## Test plan
- **Single operation:**
  - Stimulus: defaults, only requester 0 valid with 0x01020304 for one cycle, `rsp_ready`=1.
  - Required response: two cycles after the handshake, `rsp_valid`=1, `rsp_id`=0, `rsp_data`=0x00000604, for exactly one cycle.
- **Full contention:**
  - Stimulus: all four requesters valid continuously, `rsp_ready`=1.
  - Required response: grants 0,1,2,3,0,1… one per cycle; `rsp_id` follows the same sequence two cycles later.
- **Partial contention:**
  - Stimulus: only requesters 1 and 3 valid, `rr_ptr`=0 after reset.
  - Required response: grant order 1,3,1,3; requesters 0 and 2 never see `req_ready`.
- **Backpressure:**
  - Stimulus: all requesters valid, `rsp_ready`=0.
  - Required response: exactly 4 handshakes, then `req_ready`=0. Raise `rsp_ready` → responses drain in issue order, and a new grant appears the cycle after the first pop.
- **Reset mid-operation:**
  - Stimulus: assert `rst` with 1 op in flight and 2 queued.
  - Required response: next cycle `rsp_valid`=0 and `req_ready`=0. After release, the first grant goes to the lowest-index valid requester and no stale response ever appears.
- **Grant counters (`LARGE_ADDER_ARB_GRANT_CNT_EN` defined):**
  - Stimulus: 10 grants to requester 2.
  - Required response: `grant_cnt` slice 2 = 10, others 0. A forced 70000-grant run saturates at 0xFFFF.

Source files
------------

// File: rtl/large_adder_arb_pkg.sv
// Shared types and constants for the large_adder arbiter.
// Optional feature macro used by this block: LARGE_ADDER_ARB_GRANT_CNT_EN.
package large_adder_arb_pkg;

    localparam int unsigned GRANT_CNT_W = 16;
    // Widest requester index (N_REQ up to 16).
    localparam int unsigned MAX_ID_W = 4;

    function automatic int unsigned calc_id_w(input int unsigned n_req);
        return (n_req <= 2) ? 1 : $clog2(n_req);
    endfunction

    // One stage of the adder-latency tag pipeline.
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/large_adder_arb_rsp_fifo.sv
// Synchronous response FIFO of {id, data} with occupancy count.
// Head reads as zero while empty.
module large_adder_arb_rsp_fifo
    import large_adder_arb_pkg::*;
#(
    parameter int unsigned Width = 34,
    parameter int unsigned Depth = 4,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [CntW-1:0]  count
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_pop;

    assign empty  = (count_q == '0);
    assign full   = (32'(count_q) == Depth);
    assign count  = count_q;
    assign do_pop = pop && !empty;
    assign head   = empty ? '0 : mem[rd_ptr_q];

    // Storage array, written on push; no reset needed as empty masks the head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CntW'(push) - CntW'(do_pop);
        end
    end

    // The upstream credit scheme must never push into a full FIFO.
    no_overflow_a: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/large_adder_arbiter.sv
// Round-robin arbiter sharing one large_adder between N_REQ requesters.
// Tracks requester ids through the adder latency and returns tagged results
// through a credit-protected response FIFO.
// Optional: define LARGE_ADDER_ARB_GRANT_CNT_EN for saturating per-requester grant counters.
module large_adder_arbiter
    import large_adder_arb_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned ADD_LAT   = 1,
    parameter int unsigned RSP_DEPTH = 4,
    localparam int unsigned ID_W     = calc_id_w(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]         add_data_in,
    input  logic [WIDTH-1:0]         add_data_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data
`ifdef LARGE_ADDER_ARB_GRANT_CNT_EN
    ,
    output logic [N_REQ*GRANT_CNT_W-1:0] grant_cnt
`endif
);
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    tag_t                  tag_q [ADD_LAT];
    logic                  grant_vld;
    logic [ID_W-1:0]       grant_id;
    logic [WIDTH-1:0]      req_word [N_REQ];
    int unsigned           inflight;
    logic                  issue_ok;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty, fifo_full;
    logic [ID_W+WIDTH-1:0] fifo_head;
    logic                  push, pop;

    // Credit check uses registered occupancy only: a same-cycle pop frees nothing yet.
    always_comb begin
        inflight = 0;
        for (int unsigned i = 0; i < ADD_LAT; i++) begin
            inflight = inflight + 32'(tag_q[i].valid);
        end
        issue_ok = !rst && ((32'(fifo_count) + inflight) < RSP_DEPTH);
    end

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        logic [ID_W-1:0] cand;
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        if (issue_ok) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                cand = ID_W'((32'(rr_ptr_q) + k) % N_REQ);
                if (!grant_vld && req_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_id  = cand;
                end
            end
        end
    end

    // Grant decode, operand mux to the adder and next round-robin pointer.
    always_comb begin
        req_ready = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            req_word[k] = req_data[k*WIDTH +: WIDTH];
        end
        add_data_in = '0;
        rr_ptr_d    = rr_ptr_q;
        if (grant_vld) begin
            req_ready[grant_id] = 1'b1;
            add_data_in         = req_word[grant_id];
            rr_ptr_d            = (32'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
        end
    end

    // Round-robin pointer and tag pipeline mirroring the adder latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            for (int unsigned i = 0; i < ADD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            tag_q[0].valid <= grant_vld;
            tag_q[0].id    <= MAX_ID_W'(grant_id);
            for (int unsigned i = 1; i < ADD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign push      = tag_q[ADD_LAT-1].valid;
    assign rsp_valid = !fifo_empty;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_id    = fifo_head[WIDTH +: ID_W];
    assign rsp_data  = fifo_head[WIDTH-1:0];

    large_adder_arb_rsp_fifo #(
        .Width (ID_W + WIDTH),
        .Depth (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({tag_q[ADD_LAT-1].id[ID_W-1:0], add_data_out}),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

`ifdef LARGE_ADDER_ARB_GRANT_CNT_EN
    logic [GRANT_CNT_W-1:0] grant_cnt_q [N_REQ];

    // Per-requester grant counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                grant_cnt_q[k] <= '0;
            end
        end else if (grant_vld && (grant_cnt_q[grant_id] != '1)) begin
            grant_cnt_q[grant_id] <= grant_cnt_q[grant_id] + 1'b1;
        end
    end

    // Flatten counters onto the export bus.
    always_comb begin
        grant_cnt = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            grant_cnt[k*GRANT_CNT_W +: GRANT_CNT_W] = grant_cnt_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_large_adder_arbiter.sv
// Bench for large_adder_arbiter: behavioural adder plus a transaction-level
// reference (issued-minus-popped credit, response queue with visibility time).
module tb_large_adder_arbiter;
    localparam int unsigned WIDTH     = 32;
    localparam int unsigned N_REQ     = 4;
    localparam int unsigned RSP_DEPTH = 4;
    localparam int unsigned ID_W      = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]       add_in, add_out;
    logic                   rsp_valid, rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [WIDTH-1:0]       rsp_data;
`ifdef LARGE_ADDER_ARB_GRANT_CNT_EN
    logic [N_REQ*16-1:0]    grant_cnt;
`endif

    large_adder_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .add_data_in  (add_in),
        .add_data_out (add_out),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data)
`ifdef LARGE_ADDER_ARB_GRANT_CNT_EN
        ,
        .grant_cnt    (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in adder: pairwise byte sums, one cycle of latency.
    function automatic logic [31:0] adder_ref(input logic [31:0] x);
        logic [7:0] lo, hi;
        lo = x[31:24] + x[15:8];
        hi = x[23:16] + x[7:0];
        return {16'h0, hi, lo};
    endfunction

    always_ff @(posedge clk) add_out <= rst ? '0 : adder_ref(add_in);

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          id;
        logic [31:0] data;
        int          vis;
    } rsp_t;

    rsp_t        rq[$];
    int          ptr = 0;
    int          outstanding = 0;
    int          cyc = 0;
    int          hs = 0;
    logic [15:0] cnt_m [N_REQ];

    // One clock: drive, check outputs against the model, advance the model.
    task automatic step(input logic r, input logic [N_REQ-1:0] v,
                        input logic [N_REQ*WIDTH-1:0] d, input logic rr);
        int               g;
        logic [N_REQ-1:0] exp_ready;
        logic [31:0]      exp_add;
        logic             exp_rv;
        rsp_t             e;
        rst = r; req_valid = v; req_data = d; rsp_ready = rr;
        #1;
        g = -1;
        if (!r && outstanding < int'(RSP_DEPTH)) begin
            for (int k = 0; k < int'(N_REQ); k++) begin
                int i;
                i = (ptr + k) % int'(N_REQ);
                if (g < 0 && v[i]) g = i;
            end
        end
        exp_ready = '0;
        exp_add   = '0;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            exp_add      = d[g*WIDTH +: WIDTH];
        end
        check_val("req_ready", 64'(req_ready), 64'(exp_ready));
        check_val("add_data_in", 64'(add_in), 64'(exp_add));
        exp_rv = 1'b0;
        if (!r) begin
            exp_rv = (rq.size() > 0) && (rq[0].vis <= cyc);
            check_val("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            if (exp_rv) begin
                check_val("rsp_id", 64'(rsp_id), 64'(rq[0].id));
                check_val("rsp_data", 64'(rsp_data), 64'(rq[0].data));
            end
        end
        if ((req_ready & v) != '0) hs++;
        @(posedge clk);
        if (r) begin
            rq.delete();
            outstanding = 0;
            ptr = 0;
            for (int k = 0; k < int'(N_REQ); k++) cnt_m[k] = '0;
        end else begin
            if (exp_rv && rr) begin
                void'(rq.pop_front());
                outstanding--;
            end
            if (g >= 0) begin
                e.id = g; e.data = adder_ref(exp_add); e.vis = cyc + 2;
                rq.push_back(e);
                outstanding++;
                ptr = (g + 1) % int'(N_REQ);
                if (cnt_m[g] != 16'hFFFF) cnt_m[g] = cnt_m[g] + 16'd1;
            end
        end
        cyc++;
        #1;
    endtask

    function automatic logic [N_REQ*WIDTH-1:0] rand_data();
        logic [N_REQ*WIDTH-1:0] d;
        for (int k = 0; k < int'(N_REQ); k++) d[k*WIDTH +: WIDTH] = $urandom;
        return d;
    endfunction

    task automatic do_reset();
        step(1'b1, '0, '0, 1'b1);
        step(1'b1, '0, '0, 1'b1);
    endtask

    initial begin
        logic [N_REQ*WIDTH-1:0] d;
        for (int k = 0; k < int'(N_REQ); k++) cnt_m[k] = '0;
        rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
        @(posedge clk); #1;

        // Reset state
        do_reset();
        check_val("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("reset_rsp_id", 64'(rsp_id), 64'd0);
        check_val("reset_rsp_data", 64'(rsp_data), 64'd0);

        // Single operation from requester 0
        d = '0;
        d[31:0] = 32'h01020304;
        step(1'b0, 4'b0001, d, 1'b1);
        check_val("single_t1_valid", 64'(rsp_valid), 64'd0);
        step(1'b0, '0, '0, 1'b1);
        check_val("single_t2_valid", 64'(rsp_valid), 64'd1);
        check_val("single_t2_id", 64'(rsp_id), 64'd0);
        check_val("single_t2_data", 64'(rsp_data), 64'h604);
        step(1'b0, '0, '0, 1'b1);
        check_val("single_t3_valid", 64'(rsp_valid), 64'd0);

        // Full contention
        do_reset();
        for (int n = 0; n < 16; n++) step(1'b0, 4'b1111, rand_data(), 1'b1);
        for (int n = 0; n < 3; n++) step(1'b0, '0, '0, 1'b1);

        // Partial contention: only 1 and 3
        do_reset();
        for (int n = 0; n < 8; n++) step(1'b0, 4'b1010, rand_data(), 1'b1);
        for (int n = 0; n < 3; n++) step(1'b0, '0, '0, 1'b1);

        // Backpressure: credit stops at RSP_DEPTH, then drain
        do_reset();
        hs = 0;
        for (int n = 0; n < 8; n++) step(1'b0, 4'b1111, rand_data(), 1'b0);
        check_val("bp_handshakes", 64'(hs), 64'd4);
        check_val("bp_ready_low", 64'(req_ready), 64'd0);
        for (int n = 0; n < 10; n++) step(1'b0, 4'b1111, rand_data(), 1'b1);
        for (int n = 0; n < 4; n++) step(1'b0, '0, '0, 1'b1);

        // Reset with one op in flight and two queued
        do_reset();
        for (int n = 0; n < 3; n++) step(1'b0, 4'b1111, rand_data(), 1'b0);
        step(1'b1, 4'b1111, rand_data(), 1'b0);
        check_val("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        step(1'b1, 4'b1111, rand_data(), 1'b1);
        for (int n = 0; n < 6; n++) step(1'b0, 4'b1100, rand_data(), 1'b1);
        for (int n = 0; n < 4; n++) step(1'b0, '0, '0, 1'b1);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 400; n++) begin
            step(1'b0, N_REQ'($urandom), rand_data(), ($urandom_range(0, 3) != 0));
        end
        for (int n = 0; n < 10; n++) step(1'b0, '0, '0, 1'b1);

`ifdef LARGE_ADDER_ARB_GRANT_CNT_EN
        // Grant counters
        do_reset();
        for (int n = 0; n < 10; n++) step(1'b0, 4'b0100, rand_data(), 1'b1);
        check_val("cnt_r2", 64'(grant_cnt[2*16 +: 16]), 64'd10);
        check_val("cnt_r0", 64'(grant_cnt[0 +: 16]), 64'd0);
        check_val("cnt_r1", 64'(grant_cnt[16 +: 16]), 64'd0);
        check_val("cnt_r3", 64'(grant_cnt[3*16 +: 16]), 64'd0);
        for (int n = 0; n < 70000; n++) step(1'b0, 4'b0001, '0, 1'b1);
        check_val("cnt_sat_r0", 64'(grant_cnt[0 +: 16]), 64'hFFFF);
        check_val("cnt_sat_r2", 64'(grant_cnt[2*16 +: 16]), 64'd10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
